// File: rtl/vga_copper.sv
// vga_copper: display-list sequencer for the VGA core.
// A small command RAM of {offset, data} pairs is replayed as single Wishbone
// writes into the VGA core's register file. Writes to the wait-for-condition
// register stall until the core acks; every other write is guarded by a
// watchdog. Optional loop mode replays the list continuously until stopped.
module vga_copper #(
    parameter int          DEPTH    = 32,
    parameter int          AW       = 5,
    parameter logic [31:0] VGA_BASE = 32'h0400_0000,
    parameter logic [7:0]  WAIT_OFS = 8'h18,
    parameter int          TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [39:0]   load_data,
    input  logic [AW:0]   list_len,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] pc,
    output logic [31:0]   wb_addr_o,
    output logic [31:0]   wb_data_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BUS   = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   pc_reg;
    logic [AW:0]     len_reg;
    logic            loop_reg;
    logic            stop_req_reg;
    logic            error_reg;
    logic            done_reg;
    logic            stb_reg;
    logic [9:0]      wdog_reg;

    // Command storage; contents survive reset on purpose so a list can be
    // loaded once and replayed after a system reset.
    logic [39:0]     ram [DEPTH];
    logic [39:0]     rd_reg;

    logic            last_cmd;
    logic            is_wait_cmd;

    assign last_cmd    = ({1'b0, pc_reg} == (len_reg - 1'b1));
    assign is_wait_cmd = (rd_reg[39:32] == WAIT_OFS);

    // Loader port: writes are only accepted while the sequencer is idle so a
    // running list can never be modified underneath the bus cycle.
    always_ff @(posedge clk) begin
        if (load_we && (state_reg == IDLE)) begin
            ram[load_addr] <= load_data;
        end
    end

    // Registered RAM read, issued only in FETCH so the read word (and thus
    // the bus address/data) stays frozen for the whole BUS phase.
    always_ff @(posedge clk) begin
        if ((state_reg == FETCH) && !stop_req_reg) begin
            rd_reg <= ram[pc_reg];
        end
    end

    // Sequencer FSM with registered strobe, done pulse, error flag and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            len_reg      <= '0;
            loop_reg     <= 1'b0;
            stop_req_reg <= 1'b0;
            error_reg    <= 1'b0;
            done_reg     <= 1'b0;
            stb_reg      <= 1'b0;
            wdog_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            if (stop && (state_reg != IDLE)) begin
                stop_req_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg      <= list_len;
                        loop_reg     <= loop;
                        error_reg    <= 1'b0;
                        pc_reg       <= '0;
                        stop_req_reg <= 1'b0;
                        if (list_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (stop_req_reg) begin
                        done_reg     <= 1'b1;
                        stop_req_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        stb_reg   <= 1'b1;
                        wdog_reg  <= '0;
                        state_reg <= BUS;
                    end
                end

                BUS: begin
                    if (wb_ack_i) begin
                        stb_reg   <= 1'b0;
                        state_reg <= GAP;
                    end else if (!is_wait_cmd) begin
                        // Abort a write the core never answers; skip GAP.
                        if (wdog_reg == 10'(TIMEOUT - 1)) begin
                            stb_reg      <= 1'b0;
                            error_reg    <= 1'b1;
                            done_reg     <= 1'b1;
                            stop_req_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end else begin
                            wdog_reg <= wdog_reg + 10'd1;
                        end
                    end
                end

                GAP: begin
                    // The core's trailing ack lands here and is ignored.
                    if (stop_req_reg || (last_cmd && !loop_reg)) begin
                        done_reg     <= 1'b1;
                        stop_req_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (last_cmd) begin
                        pc_reg    <= '0;
                        state_reg <= FETCH;
                    end else begin
                        pc_reg    <= pc_reg + 1'b1;
                        state_reg <= FETCH;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign error     = error_reg;
    assign pc        = pc_reg;
    assign wb_stb_o  = stb_reg;
    assign wb_cyc_o  = stb_reg;
    assign wb_we_o   = stb_reg;
    assign wb_sel_o  = 4'hF;
    // Address/data are zero outside a bus cycle so reset leaves the bus quiet.
    assign wb_addr_o = stb_reg ? (VGA_BASE | {24'h0, rd_reg[39:32]}) : 32'h0;
    assign wb_data_o = stb_reg ? rd_reg[31:0] : 32'h0;

endmodule

// File: tb/tb_vga_copper.sv
// Testbench for vga_copper: a Wishbone slave model with programmable ack
// behaviour records every write; each scenario task compares the recorded
// writes against a list-replay model built from the loaded commands.
module tb_vga_copper;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [39:0]   load_data = '0;
    logic [AW:0]   list_len = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] pc;
    logic [31:0]   wb_addr_o, wb_data_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_stb_o, wb_cyc_o;
    logic          wb_ack_i = 1'b0;

    vga_copper dut (
        .clk(clk), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .list_len(list_len), .loop(loop), .start(start), .stop(stop),
        .busy(busy), .done(done), .error(error), .pc(pc),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  pc;
        int          cycles;
        int          gap;
        bit          unstable;
    } wr_t;

    int  n_checks = 0;
    int  n_fail   = 0;

    wr_t obs[$];
    wr_t exp_q[$];
    wr_t cur;
    logic [39:0] model_ram [DEPTH];

    int  ack_delay = 1;
    bit  never_ack = 1'b0;
    bit  hold_ack  = 1'b0;
    bit  prev_stb  = 1'b0;
    int  low_run   = 0;
    int  rises     = 0;
    int  done_cnt  = 0;

    // Slave model: samples on the falling edge, acks after ack_delay strobe
    // cycles, optionally keeps ack high one cycle after the strobe drops.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wb_stb_o === 1'b1) begin
            if (!prev_stb) begin
                cur.addr = wb_addr_o;
                cur.data = wb_data_o;
                cur.pc = pc;
                cur.cycles = 0;
                cur.gap = low_run;
                cur.unstable = 1'b0;
                rises++;
            end else if (wb_addr_o !== cur.addr || wb_data_o !== cur.data) begin
                cur.unstable = 1'b1;
            end
            if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_sel_o !== 4'hF) cur.unstable = 1'b1;
            cur.cycles++;
            wb_ack_i = !never_ack && (cur.cycles >= ack_delay);
            low_run = 0;
            prev_stb = 1'b1;
        end else begin
            if (prev_stb) obs.push_back(cur);
            wb_ack_i = hold_ack && prev_stb && wb_ack_i;
            low_run++;
            prev_stb = 1'b0;
        end
    end

    // Replay model: write i of a run is command (i mod len).
    function automatic void build_expected(input int len, input int nwr);
        wr_t e;
        exp_q.delete();
        for (int i = 0; i < nwr; i++) begin
            int idx = i % len;
            e.addr = 32'h0400_0000 | {24'h0, model_ram[idx][39:32]};
            e.data = model_ram[idx][31:0];
            e.pc = idx[4:0];
            e.cycles = 0;
            e.gap = 0;
            e.unstable = 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic load_cmd(input int a, input logic [7:0] ofs, input logic [31:0] d, input bit track);
        @(negedge clk);
        load_we = 1'b1;
        load_addr = a[AW-1:0];
        load_data = {ofs, d};
        @(negedge clk);
        load_we = 1'b0;
        if (track) model_ram[a] = {ofs, d};
    endtask

    task automatic pulse_start(input int len, input bit lp);
        @(negedge clk);
        list_len = len[AW:0];
        loop = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done after %0d cycles, required a done pulse", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_stb(input int budget, input string name);
        int n = 0;
        while (wb_stb_o !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_checks++;
        if (wb_stb_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_stb_timeout: stb=%b after %0d cycles, required 1", name, wb_stb_o, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, error, wb_stb_o, wb_cyc_o, wb_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/error/stb/cyc/we=%b required 000000",
                     {busy, done, error, wb_stb_o, wb_cyc_o, wb_we_o});
        end
        n_checks++;
        if (pc !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_pc: pc=%0d required 0", pc);
        end
        n_checks++;
        if ({wb_addr_o, wb_data_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h data=%h required 0", wb_addr_o, wb_data_o);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, wb_stb_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy/done/error/stb=%b required 0000", {busy, done, error, wb_stb_o});
        end
    endtask

    task automatic test_basic;
        int d0;
        load_cmd(0, 8'h00, 32'h1111_0000 | $urandom_range(0, 16'hFFFF), 1);
        load_cmd(1, 8'h04, 32'h2222_0000 | $urandom_range(0, 16'hFFFF), 1);
        load_cmd(2, 8'h08, 32'h3333_0000 | $urandom_range(0, 16'hFFFF), 1);
        ack_delay = 1; hold_ack = 0; never_ack = 0;
        obs.delete(); d0 = done_cnt;
        pulse_start(3, 0);
        wait_done(d0, 100, "basic");
        build_expected(3, 3);
        n_checks++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: %0d writes, required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            $display("basic write %0d: addr=%h data=%h pc=%0d stb_cycles=%0d gap=%0d",
                     i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].cycles, obs[i].gap);
            n_checks++;
            if ({obs[i].addr, obs[i].data, obs[i].pc, obs[i].unstable} !==
                {exp_q[i].addr, exp_q[i].data, exp_q[i].pc, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_write%0d: addr=%h data=%h pc=%0d unstable=%b required addr=%h data=%h pc=%0d stable",
                         i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].unstable, exp_q[i].addr, exp_q[i].data, exp_q[i].pc);
            end
            if (i > 0) begin
                n_checks++;
                if (obs[i].gap < 1) begin
                    n_fail++;
                    $display("FAIL basic_gap%0d: stb low %0d cycles, required >=1", i, obs[i].gap);
                end
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: done pulses=%0d busy=%b error=%b required 1/0/0", done_cnt - d0, busy, error);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int len, d0;
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                logic [7:0] ofs;
                ofs = 8'(4 * $urandom_range(0, 8));
                if (ofs == 8'h18) ofs = 8'h1C;
                load_cmd(c, ofs, $urandom, 1);
            end
            ack_delay = $urandom_range(1, 4);
            hold_ack = 1'($urandom_range(0, 1));
            obs.delete(); d0 = done_cnt;
            pulse_start(len, 0);
            wait_done(d0, 400, "random");
            build_expected(len, len);
            n_checks++;
            if (obs.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL random_count: run %0d has %0d writes, required %0d", it, obs.size(), exp_q.size());
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                $display("random run %0d write %0d: addr=%h data=%h pc=%0d stb_cycles=%0d",
                         it, i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].cycles);
                n_checks++;
                if ({obs[i].addr, obs[i].data, obs[i].pc, obs[i].unstable} !==
                    {exp_q[i].addr, exp_q[i].data, exp_q[i].pc, 1'b0} || obs[i].cycles !== ack_delay) begin
                    n_fail++;
                    $display("FAIL random_write%0d_%0d: addr=%h data=%h pc=%0d cycles=%0d required addr=%h data=%h pc=%0d cycles=%0d",
                             it, i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].cycles,
                             exp_q[i].addr, exp_q[i].data, exp_q[i].pc, ack_delay);
                end
            end
            n_checks++;
            if (done_cnt - d0 !== 1 || busy !== 1'b0 || error !== 1'b0) begin
                n_fail++;
                $display("FAIL random_end%0d: done pulses=%0d busy=%b error=%b required 1/0/0", it, done_cnt - d0, busy, error);
            end
        end
        hold_ack = 0;
    endtask

    task automatic test_wait_cond;
        int d0;
        load_cmd(0, 8'h18, 32'h0400_0000, 1);
        load_cmd(1, 8'h04, $urandom, 1);
        ack_delay = 500;
        obs.delete(); d0 = done_cnt;
        pulse_start(2, 0);
        wait_done(d0, 1500, "wait");
        build_expected(2, 2);
        n_checks++;
        if (obs.size() !== 2) begin
            n_fail++;
            $display("FAIL wait_count: %0d writes, required 2", obs.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                $display("wait write %0d: addr=%h data=%h stb_cycles=%0d", i, obs[i].addr, obs[i].data, obs[i].cycles);
                n_checks++;
                if ({obs[i].addr, obs[i].data} !== {exp_q[i].addr, exp_q[i].data} || obs[i].cycles < 500) begin
                    n_fail++;
                    $display("FAIL wait_write%0d: addr=%h data=%h cycles=%0d required addr=%h data=%h cycles>=500",
                             i, obs[i].addr, obs[i].data, obs[i].cycles, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_error: error=%b required 0", error);
        end
        ack_delay = 1;
    endtask

    task automatic test_timeout;
        int d0;
        load_cmd(0, 8'h1C, $urandom, 1);
        never_ack = 1;
        obs.delete(); d0 = done_cnt;
        pulse_start(1, 0);
        wait_done(d0, 3000, "timeout");
        never_ack = 0;
        if (obs.size() > 0)
            $display("timeout write 0: addr=%h stb_cycles=%0d", obs[0].addr, obs[0].cycles);
        n_checks++;
        if (obs.size() !== 1 || (obs.size() > 0 && obs[0].cycles !== 1023)) begin
            n_fail++;
            $display("FAIL timeout_stb: writes=%0d cycles=%0d required 1 write with 1023 cycles",
                     obs.size(), (obs.size() > 0) ? obs[0].cycles : -1);
        end
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_flags: error=%b busy=%b done pulses=%0d required 1/0/1", error, busy, done_cnt - d0);
        end
        load_cmd(0, 8'h00, $urandom, 1);
        d0 = done_cnt;
        pulse_start(1, 0);
        #1;
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: error=%b after start, required 0", error);
        end
        wait_done(d0, 100, "timeout_rerun");
    endtask

    task automatic test_loop_stop;
        int d0, r0, k, n;
        load_cmd(0, 8'h08, $urandom, 1);
        load_cmd(1, 8'h0C, $urandom, 1);
        ack_delay = 3;
        k = $urandom_range(3, 4);
        obs.delete(); d0 = done_cnt; r0 = rises;
        pulse_start(2, 1);
        n = 0;
        while (!(rises == r0 + k && wb_stb_o === 1'b1) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(d0, 200, "loop_stop");
        repeat (20) @(negedge clk);
        build_expected(2, k);
        n_checks++;
        if (obs.size() !== k) begin
            n_fail++;
            $display("FAIL loop_count: %0d writes, required %0d", obs.size(), k);
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            $display("loop write %0d: addr=%h data=%h pc=%0d", i, obs[i].addr, obs[i].data, obs[i].pc);
            n_checks++;
            if ({obs[i].addr, obs[i].data, obs[i].pc} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].pc}) begin
                n_fail++;
                $display("FAIL loop_write%0d: addr=%h data=%h pc=%0d required addr=%h data=%h pc=%0d",
                         i, obs[i].addr, obs[i].data, obs[i].pc, exp_q[i].addr, exp_q[i].data, exp_q[i].pc);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || wb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_end: done pulses=%0d busy=%b stb=%b required 1/0/0", done_cnt - d0, busy, wb_stb_o);
        end
        ack_delay = 1;
    endtask

    task automatic test_gap_ack;
        int d0, r0;
        for (int c = 0; c < 5; c++) load_cmd(c, 8'(4 * c), $urandom, 1);
        ack_delay = 1; hold_ack = 1;
        obs.delete(); d0 = done_cnt;
        pulse_start(5, 0);
        wait_done(d0, 200, "gap_ack");
        hold_ack = 0;
        build_expected(5, 5);
        n_checks++;
        if (obs.size() !== 5) begin
            n_fail++;
            $display("FAIL gap_count: %0d writes, required 5", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            $display("gap_ack write %0d: addr=%h data=%h pc=%0d stb_cycles=%0d", i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].cycles);
            n_checks++;
            if ({obs[i].addr, obs[i].data, obs[i].pc} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].pc} || obs[i].cycles !== 1) begin
                n_fail++;
                $display("FAIL gap_write%0d: addr=%h data=%h pc=%0d cycles=%0d required addr=%h data=%h pc=%0d cycles=1",
                         i, obs[i].addr, obs[i].data, obs[i].pc, obs[i].cycles, exp_q[i].addr, exp_q[i].data, exp_q[i].pc);
            end
        end
        // Empty list: done on the following cycle, no bus activity.
        d0 = done_cnt; r0 = rises;
        @(negedge clk);
        list_len = '0; loop = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%b busy=%b required 1/0", done, busy);
        end
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || rises !== r0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_bus: done pulses=%0d stb cycles=%0d done=%b required 1/0/0", done_cnt - d0, rises - r0, done);
        end
    endtask

    task automatic test_load_busy;
        int d0;
        logic [31:0] orig;
        orig = $urandom;
        load_cmd(0, 8'h04, orig, 1);
        ack_delay = 30;
        obs.delete(); d0 = done_cnt;
        pulse_start(1, 0);
        wait_stb(20, "load_busy");
        load_cmd(0, 8'h0C, ~orig, 0);
        wait_done(d0, 200, "load_busy");
        ack_delay = 1;
        obs.delete(); d0 = done_cnt;
        pulse_start(1, 0);
        wait_done(d0, 100, "load_busy_rerun");
        build_expected(1, 1);
        n_checks++;
        if (obs.size() !== 1 || (obs.size() > 0 && {obs[0].addr, obs[0].data} !== {exp_q[0].addr, exp_q[0].data})) begin
            n_fail++;
            $display("FAIL load_busy_ram: writes=%0d addr=%h data=%h required 1 write addr=%h data=%h",
                     obs.size(), (obs.size() > 0) ? obs[0].addr : 32'h0, (obs.size() > 0) ? obs[0].data : 32'h0,
                     exp_q[0].addr, exp_q[0].data);
        end
        if (obs.size() > 0) $display("load_busy write 0: addr=%h data=%h", obs[0].addr, obs[0].data);
    endtask

    task automatic test_reset_mid;
        load_cmd(0, 8'h18, $urandom, 1);
        never_ack = 1;
        obs.delete();
        pulse_start(1, 0);
        wait_stb(20, "reset_mid");
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (1100) @(negedge clk);
        #1;
        n_checks++;
        if (wb_stb_o !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_no_abort: stb=%b busy=%b error=%b required 1/1/0", wb_stb_o, busy, error);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({wb_stb_o, wb_cyc_o, wb_we_o, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: stb/cyc/we/busy/done=%b required 00000", {wb_stb_o, wb_cyc_o, wb_we_o, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        never_ack = 0;
        repeat (2) @(negedge clk);
        $display("reset_mid: writes recorded=%0d", obs.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_wait_cond();
        test_timeout();
        test_loop_stop();
        test_gap_ack();
        test_load_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
